// File: rtl/float_a_div_b16.sv
// IEEE-754 binary16 divider (RNE) built on a 13-step restoring mantissa divider.
// Fixed 14-cycle latency from accepted start to done, special operands included.
module float_a_div_b16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] numA,
  input  logic [15:0] numB,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

  state_t             state, state_nx;
  logic [3:0]         cnt;
  logic [11:0]        rem;
  logic [12:0]        q;
  logic [10:0]        mb;
  logic signed [6:0]  exp_r;
  logic               sign_r;
  logic               spec_r;
  logic [15:0]        spec_val;

  // operand classification (subnormals count as zero)
  logic [4:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic        spec_hit;
  logic [15:0] spec_res;

  assign ea     = numA[14:10];
  assign eb     = numB[14:10];
  assign sgn    = numA[15] ^ numB[15];
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_inf  = (ea == 5'h1F) && (numA[9:0] == 10'd0);
  assign b_inf  = (eb == 5'h1F) && (numB[9:0] == 10'd0);
  assign a_nan  = (ea == 5'h1F) && (numA[9:0] != 10'd0);
  assign b_nan  = (eb == 5'h1F) && (numB[9:0] != 10'd0);

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_res = 16'h7E00;
    else if (a_inf || b_zero)
      spec_res = {sgn, 5'h1F, 10'h000};
    else if (a_zero || b_inf)
      spec_res = {sgn, 15'h0000};
    else
      spec_hit = 1'b0;
  end

  // one restoring step
  logic        ge;
  logic [11:0] diff, rem_nx;

  assign ge     = (rem >= {1'b0, mb});
  assign diff   = ge ? (rem - {1'b0, mb}) : rem;
  assign rem_nx = diff << 1;

  // normalize, round to nearest even, range check
  logic              norm, guard, sticky, round_up, carry;
  logic [9:0]        frac_pre, frac;
  logic signed [6:0] exp_n, exp_f;
  logic [15:0]       res, res_fin;

  always_comb begin
    norm     = q[12];
    frac_pre = norm ? q[11:2] : q[10:1];
    guard    = norm ? q[1] : q[0];
    sticky   = (norm & q[0]) | (rem != 12'd0);
    exp_n    = norm ? exp_r : exp_r - 7'sd1;
    round_up = guard & (sticky | frac_pre[0]);
    carry    = round_up & (&frac_pre);
    frac     = frac_pre + {9'd0, round_up};
    exp_f    = carry ? exp_n + 7'sd1 : exp_n;
    if (exp_f >= 7'sd31)
      res = {sign_r, 5'h1F, 10'h000};
    else if (exp_f <= 7'sd0)
      res = {sign_r, 15'h0000};
    else
      res = {sign_r, exp_f[4:0], frac};
    res_fin = spec_r ? spec_val : res;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DIV;
      DIV:     if (cnt == 4'd12) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      q        <= '0;
      mb       <= '0;
      exp_r    <= '0;
      sign_r   <= 1'b0;
      spec_r   <= 1'b0;
      spec_val <= '0;
      done     <= 1'b0;
      out      <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == ROUND);
      case (state)
        IDLE: if (start) begin
          rem      <= {2'b01, numA[9:0]};
          mb       <= {1'b1, numB[9:0]};
          q        <= '0;
          cnt      <= '0;
          exp_r    <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
          sign_r   <= sgn;
          spec_r   <= spec_hit;
          spec_val <= spec_res;
        end
        DIV: begin
          q   <= {q[11:0], ge};
          rem <= rem_nx;
          cnt <= cnt + 4'd1;
        end
        ROUND:   out <= res_fin;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_a_div_b16.sv
// Self-checking bench for float_a_div_b16: directed vectors, random vs. exact model, control corner cases.
module tb_float_a_div_b16;

  logic        clk, rst_n, start;
  logic [15:0] numA, numB;
  logic        busy, done;
  logic [15:0] out;

  int tests = 0;
  int fails = 0;

  float_a_div_b16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .numA  (numA),
    .numB  (numB),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact-quotient reference: integer division, then RNE from the true remainder.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, e;
    longint fa, fb, ma, mb, num, qq, r;
    logic   s;
    logic [15:0] res;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = longint'(a[9:0]); fb = longint'(b[9:0]);
    s  = a[15] ^ b[15];
    if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) return 16'h7E00;
    if ((ea == 0 && eb == 0) || (ea == 31 && eb == 31)) return 16'h7E00;
    if (ea == 31 || eb == 0) return {s, 15'h7C00};
    if (ea == 0 || eb == 31) return {s, 15'h0000};
    ma = 1024 + fa; mb = 1024 + fb;
    e  = ea - eb + 15;
    if (ma >= mb) num = ma * 1024;
    else begin num = ma * 2048; e = e - 1; end
    qq = num / mb; r = num % mb;
    if (2 * r > mb || (2 * r == mb && (qq % 2) == 1)) qq = qq + 1;
    if (qq == 2048) begin qq = 1024; e = e + 1; end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0)  return {s, 15'h0000};
    res = {s, 5'(e), 10'(qq - 1024)};
    return res;
  endfunction

  // Launches one divide; returns result and the number of edges after the accepting edge until done (0 = timeout).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output int lat);
    @(negedge clk);
    numA = a; numB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    res = out;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; numA = '0; numB = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b out=%h, want 0 0 0000", busy, done, out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [15:0] va [12] = '{16'h2BC5, 16'h2F30, 16'h1448, 16'h3C00, 16'h0000, 16'h7C00,
                             16'h0000, 16'h7BFF, 16'h0400, 16'h3C00, 16'h7E01, 16'hFC00};
    logic [15:0] vb [12] = '{16'h2B1E, 16'h92AD, 16'hC367, 16'h0000, 16'h0000, 16'h7C00,
                             16'hBC00, 16'h0400, 16'h7BFF, 16'h4200, 16'h3C00, 16'h4000};
    logic [15:0] ve [12] = '{16'h3C5E, 16'hD84E, 16'h8CA0, 16'h7C00, 16'h7E00, 16'h7E00,
                             16'h8000, 16'h7C00, 16'h0000, 16'h3555, 16'h7E00, 16'hFC00};
    logic [15:0] r;
    int lat;
    for (int i = 0; i < 12; i++) begin
      do_op(va[i], vb[i], r, lat);
      tests++;
      if (r !== ve[i]) begin
        fails++;
        $display("FAIL directed[%0d] %h/%h: got %h want %h", i, va[i], vb[i], r, ve[i]);
      end
      tests++;
      if (lat !== 14) begin
        fails++;
        $display("FAIL latency[%0d]: got %0d edges want 14", i, lat);
      end
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_after_done[%0d]: got %b want 0", i, busy);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b, r, exp_v;
    int lat;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      // keep many operands near unity so the rounding paths get exercised
      if ((i % 2) == 0) begin
        a[14:10] = 5'(13 + $urandom_range(0, 4));
        b[14:10] = 5'(13 + $urandom_range(0, 4));
      end
      exp_v = model(a, b);
      do_op(a, b, r, lat);
      tests++;
      if (r !== exp_v || lat !== 14) begin
        fails++;
        $display("FAIL random[%0d] %h/%h: got %h lat %0d want %h lat 14", i, a, b, r, lat, exp_v);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat, extra;
    @(negedge clk);
    numA = 16'h3C00; numB = 16'h4200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_set: got %b want 1", busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    numA = 16'h4800; numB = 16'h3C00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int n = 5; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    tests++;
    if (lat !== 14 || out !== 16'h3555) begin
      fails++;
      $display("FAIL busy_ignore: got %h lat %0d want 3555 lat 14", out, lat);
    end
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL busy_ignore_extra: got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_mid_reset;
    int seen;
    @(negedge clk);
    numA = 16'h2BC5; numB = 16'h2B1E; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: out=%h busy=%b done=%b want 0000 0 0", out, busy, done);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests++;
    if (seen !== 0 || out !== 16'h0000) begin
      fails++;
      $display("FAIL mid_reset_nodone: done pulses %0d out %h want 0 0000", seen, out);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r, a2, b2;
    int lat;
    a2 = 16'h2F30; b2 = 16'h92AD;
    do_op(16'h1448, 16'hC367, r, lat);
    tests++;
    if (r !== 16'h8CA0 || lat !== 14) begin
      fails++;
      $display("FAIL b2b_first: got %h lat %0d want 8CA0 lat 14", r, lat);
    end
    // still inside the done cycle
    numA = a2; numB = b2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    tests++;
    if (out !== model(a2, b2) || lat !== 14) begin
      fails++;
      $display("FAIL b2b_second: got %h lat %0d want %h lat 14", out, lat, model(a2, b2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
